// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, record layout and frame helpers for the UART receiver
package uart_rx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_DATA      = 4'd2,
        ST_PARITY    = 4'd3,
        ST_STOP1     = 4'd4,
        ST_STOP2     = 4'd5,
        ST_PUSH      = 4'd6,
        ST_WAIT_IDLE = 4'd7
    } rx_state_t;

    localparam int REC_W    = 12;
    localparam int DATA_MSB = 11;
    localparam int NOISE    = 3;
    localparam int BREAK    = 2;
    localparam int PERR     = 1;
    localparam int FERR     = 0;

    // Frame length in bits: start + data + optional parity + one or two stops.
    function automatic logic [3:0] frame_bits(input logic [3:0] lcr_lo);
        return 4'd7 + {2'b00, lcr_lo[1:0]} + {3'b000, lcr_lo[3]} + {3'b000, lcr_lo[2]};
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - receive FIFO push/pop interface between the receiver and its FIFO
interface uart_rx_core_if;
    import uart_rx_pkg::*;

    logic             rf_push;
    logic [REC_W-1:0] rf_data_in;
    logic             rf_pop;
    logic             fifo_empty;

    modport master (
        output rf_push,
        output rf_data_in,
        input  rf_pop,
        input  fifo_empty
    );

    modport slave (
        input  rf_push,
        input  rf_data_in,
        output rf_pop,
        output fifo_empty
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - input synchroniser, per-bit tick counter and 3-sample majority vote
module uart_rx_sampler #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic wb_rst_i,
    input  logic enable,
    input  logic srx_pad_i,
    input  logic restart,
    output logic rx_s,
    output logic bit_value,
    output logic bit_noise,
    output logic bit_done,
    output logic mid_tick
);

    localparam int TW = $clog2(OVS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          tick_q;
    logic                   s0_q;
    logic                   s1_q;

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], srx_pad_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // The tick that asserts restart is tick 0 of the new bit, so the counter resumes at 1.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            tick_q <= '0;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else if (enable) begin
            if (restart) begin
                tick_q <= TW'(1);
            end else begin
                tick_q <= tick_q + TW'(1);
                if (tick_q == TW'(OVS/2 - 1)) s0_q <= rx_s;
                if (tick_q == TW'(OVS/2))     s1_q <= rx_s;
            end
        end
    end

    // The third sample is taken live on the mid tick, so the vote is ready that same tick.
    assign mid_tick  = enable && !restart && (tick_q == TW'(OVS/2 + 1));
    assign bit_done  = enable && !restart && (tick_q == TW'(OVS - 1));
    assign bit_value = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign bit_noise = !((s0_q == s1_q) && (s1_q == rx_s));

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receive engine: frame FSM, break detector and character timeout
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TOC_W       = 10
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             enable,
    input  logic [7:0]       lcr,
    input  logic             srx_pad_i,
    uart_rx_core_if.master   fifo,
    output logic [3:0]       rstate,
    output logic [TOC_W-1:0] counter_t,
    output logic             rx_timeout
);

    localparam int CB_W = 8;

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_s;
    logic             bit_value;
    logic             bit_noise;
    logic             bit_done;
    logic             mid_tick;
    logic             restart;
    logic [5:0]       lcr_q;
    logic [7:0]       data_q;
    logic [3:0]       bit_cnt;
    logic             noise_q;
    logic             perr_q;
    logic             ferr_q;
    logic [CB_W-1:0]  counter_b;
    logic             break_det;
    logic             push_evt;
    logic [REC_W-1:0] rec_nxt;
    logic [3:0]       nbits;
    logic             exp_par;
    logic [11:0]      fb_ovs;
    logic [13:0]      toc_full;
    logic [CB_W-1:0]  cb_load;
    logic [TOC_W-1:0] toc_val;
    logic             unused_lcr;

    uart_rx_sampler #(
        .OVS         (OVS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .enable    (enable),
        .srx_pad_i (srx_pad_i),
        .restart   (restart),
        .rx_s      (rx_s),
        .bit_value (bit_value),
        .bit_noise (bit_noise),
        .bit_done  (bit_done),
        .mid_tick  (mid_tick)
    );

    assign unused_lcr = ^lcr[7:6];
    assign nbits      = 4'd5 + {2'b00, lcr_q[1:0]};
    assign exp_par    = lcr_q[5] ? ~lcr_q[4] : (lcr_q[4] ? ^data_q : ~(^data_q));

    // Break and timeout lengths follow the live lcr, not the per-frame copy.
    assign fb_ovs   = 12'(frame_bits(lcr[3:0])) * 12'(OVS);
    assign toc_full = {fb_ovs, 2'b00} - 14'd1;
    assign toc_val  = TOC_W'(toc_full);
    assign cb_load  = CB_W'(fb_ovs - 12'd1);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!rx_s) state_nxt = ST_START;
            ST_START:     if (mid_tick) state_nxt = bit_value ? ST_IDLE : ST_DATA;
            ST_DATA:      if (mid_tick && (bit_cnt == nbits))
                              state_nxt = lcr_q[3] ? ST_PARITY : ST_STOP1;
            ST_PARITY:    if (mid_tick) state_nxt = ST_STOP1;
            ST_STOP1:     if (mid_tick) state_nxt = lcr_q[2] ? ST_STOP2 : ST_PUSH;
            ST_STOP2:     if (mid_tick) state_nxt = ST_PUSH;
            ST_PUSH: begin
                if (break_det)  state_nxt = ST_WAIT_IDLE;
                else if (rx_s)  state_nxt = ST_IDLE;
            end
            ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        restart  = 1'b0;
        push_evt = 1'b0;
        rec_nxt  = '0;
        rec_nxt[DATA_MSB -: 8] = data_q;
        rec_nxt[NOISE]         = noise_q;
        rec_nxt[PERR]          = perr_q;
        rec_nxt[FERR]          = ferr_q;
        case (state)
            ST_IDLE: restart = !rx_s;
            ST_PUSH: begin
                push_evt = enable && (break_det || rx_s);
                if (break_det) begin
                    rec_nxt        = '0;
                    rec_nxt[BREAK] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // bit_cnt counts bit boundaries seen in DATA, so at a mid tick it is the 1-based data index.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            lcr_q   <= '0;
            data_q  <= '0;
            bit_cnt <= '0;
            noise_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (enable) begin
            case (state)
                ST_IDLE: if (!rx_s) begin
                    lcr_q   <= lcr[5:0];
                    data_q  <= '0;
                    bit_cnt <= '0;
                    noise_q <= 1'b0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                end
                ST_START: if (mid_tick) begin
                    noise_q <= bit_noise;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (bit_done) bit_cnt <= bit_cnt + 4'd1;
                    if (mid_tick) begin
                        data_q[3'(bit_cnt - 4'd1)] <= bit_value;
                        noise_q <= noise_q | bit_noise;
                    end
                end
                ST_PARITY: if (mid_tick) begin
                    perr_q  <= (bit_value != exp_par);
                    noise_q <= noise_q | bit_noise;
                end
                ST_STOP1: if (mid_tick) begin
                    ferr_q  <= !bit_value;
                    noise_q <= noise_q | bit_noise;
                end
                ST_STOP2: if (mid_tick) begin
                    ferr_q  <= ferr_q | !bit_value;
                    noise_q <= noise_q | bit_noise;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            counter_b <= CB_W'(10*OVS - 1);
        end else if (enable) begin
            if (rx_s)                 counter_b <= cb_load;
            else if (counter_b != '0) counter_b <= counter_b - CB_W'(1);
        end
    end

    assign break_det = (counter_b == '0);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            fifo.rf_push    <= 1'b0;
            fifo.rf_data_in <= '0;
        end else begin
            fifo.rf_push <= push_evt;
            if (push_evt) fifo.rf_data_in <= rec_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            counter_t <= TOC_W'(40*OVS - 1);
        end else if (fifo.rf_push || fifo.rf_pop || fifo.fifo_empty) begin
            counter_t <= toc_val;
        end else if (enable && (counter_t != '0)) begin
            counter_t <= counter_t - TOC_W'(1);
        end
    end

    assign rx_timeout = (counter_t == '0) && !fifo.fifo_empty;
    assign rstate     = state;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core with directed frames
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    localparam int OVS   = 16;
    localparam int TOC_W = 10;

    logic             clk       = 1'b0;
    logic             wb_rst_i  = 1'b1;
    logic             enable    = 1'b0;
    logic             srx_pad_i = 1'b1;
    logic [7:0]       lcr       = 8'h03;
    logic [3:0]       rstate;
    logic [TOC_W-1:0] counter_t;
    logic             rx_timeout;

    uart_rx_core_if fif ();

    uart_rx_core #(
        .OVS         (OVS),
        .SYNC_STAGES (2),
        .TOC_W       (TOC_W)
    ) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .enable     (enable),
        .lcr        (lcr),
        .srx_pad_i  (srx_pad_i),
        .fifo       (fif),
        .rstate     (rstate),
        .counter_t  (counter_t),
        .rx_timeout (rx_timeout)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               errors   = 0;
    int               push_cnt = 0;
    int               pc;
    logic [REC_W-1:0] exp_q[$];
    logic             push_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One oversample tick: pad value held for 4 clks, enable on the last one.
    task automatic do_tick(input logic v);
        srx_pad_i = v;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b1);
    endtask

    task automatic send_frame(input logic [11:0] bits, input int nb, input int flip_at);
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < OVS; t++) begin
                logic v;
                v = bits[b];
                if (b*OVS + t == flip_at) v = ~v;
                do_tick(v);
            end
        end
    endtask

    always @(negedge clk) begin
        if (fif.rf_push) begin
            logic [REC_W-1:0] e;
            push_cnt++;
            checks++;
            if (push_prev) begin
                errors++;
                $display("FAIL push_width: rf_push high on consecutive cycles, data %0h", fif.rf_data_in);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push: got %0h want no push", fif.rf_data_in);
            end else begin
                e = exp_q.pop_front();
                if (fif.rf_data_in !== e) begin
                    errors++;
                    $display("FAIL record: got %0h want %0h", fif.rf_data_in, e);
                end
            end
        end
        push_prev = fif.rf_push;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fif.rf_pop     = 1'b0;
        fif.fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rstate", rstate, 0);
        check("rst_push", fif.rf_push, 0);
        check("rst_data", fif.rf_data_in, 0);
        check("rst_counter_t", counter_t, 639);
        check("rst_timeout", rx_timeout, 0);
        wb_rst_i = 1'b0;
        idle(4);

        // 8N1 0xA5, push within 163 ticks of the start edge
        pc = push_cnt;
        exp_q.push_back(12'hA50);
        send_frame({1'b1, 8'hA5, 1'b0}, 10, -1);
        idle(3);
        check("8n1_push_latency", push_cnt, pc + 1);

        // 7E1 0x41, wrong then correct parity
        lcr = 8'h1A;
        exp_q.push_back(12'h412);
        send_frame({1'b1, 1'b1, 7'h41, 1'b0}, 10, -1);
        idle(4);
        exp_q.push_back(12'h410);
        send_frame({1'b1, 1'b0, 7'h41, 1'b0}, 10, -1);
        idle(4);

        // 8N2 with low second stop, then a clean 0x3C
        lcr = 8'h07;
        exp_q.push_back(12'hC31);
        send_frame({1'b0, 1'b1, 8'hC3, 1'b0}, 11, -1);
        idle(20);
        check("8n2_back_idle", rstate, 0);
        exp_q.push_back(12'h3C0);
        send_frame({2'b11, 8'h3C, 1'b0}, 11, -1);
        idle(4);

        // Short start glitch
        lcr = 8'h03;
        pc = push_cnt;
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        idle(2);
        check("glitch_in_start", rstate, 1);
        idle(10);
        check("glitch_rejected", rstate, 0);
        check("glitch_no_push", push_cnt, pc);

        // Flipped mid sample on data bit 3 of 0x55
        exp_q.push_back(12'h558);
        send_frame({1'b1, 8'h55, 1'b0}, 10, 4*OVS + OVS/2);
        idle(4);

        // Break: 30 bit-times low
        pc = push_cnt;
        exp_q.push_back(12'h004);
        for (int i = 0; i < 30*OVS; i++) do_tick(1'b0);
        check("break_one_push", push_cnt, pc + 1);
        check("break_wait_idle", rstate, 7);
        idle(20);
        check("break_no_second", push_cnt, pc + 1);
        check("break_released", rstate, 0);
        exp_q.push_back(12'h5A0);
        send_frame({1'b1, 8'h5A, 1'b0}, 10, -1);
        idle(4);
        check("after_break_push", push_cnt, pc + 2);

        // Timeout with a non-empty FIFO
        fif.fifo_empty = 1'b0;
        exp_q.push_back(12'h690);
        send_frame({1'b1, 8'h69, 1'b0}, 10, -1);
        check("toc_after_push", counter_t, 634);
        idle(295);
        check("toc_before_pop", counter_t, 339);
        fif.rf_pop = 1'b1;
        @(negedge clk);
        fif.rf_pop = 1'b0;
        check("toc_pop_reload", counter_t, 639);
        idle(638);
        check("toc_one_left", counter_t, 1);
        check("toc_not_yet", rx_timeout, 0);
        idle(1);
        check("toc_zero", counter_t, 0);
        check("toc_timeout", rx_timeout, 1);
        idle(5);
        check("toc_saturate", counter_t, 0);

        // Reset mid-frame
        pc = push_cnt;
        send_frame({1'b1, 8'h77, 1'b0}, 5, -1);
        wb_rst_i  = 1'b1;
        srx_pad_i = 1'b1;
        @(negedge clk);
        wb_rst_i = 1'b0;
        check("midrst_rstate", rstate, 0);
        check("midrst_counter_t", counter_t, 639);
        check("midrst_data", fif.rf_data_in, 0);
        check("midrst_timeout", rx_timeout, 0);
        idle(200);
        check("midrst_no_push", push_cnt, pc);
        check("midrst_idle", rstate, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine for the 16550-compatible core: oversampled serial input, majority-vote bit sampling, 5–8 data bits, optional parity, 1 or 2 stop bits, break and character-timeout detection. It sits between the pad input and the receive FIFO. It writes one status-tagged record per character into the FIFO through a single-cycle push strobe. Improvements over the previous receiver: configurable oversample rate, a noise flag, a true second-stop-bit check, and an explicit timeout output.

## Interface
Parameters:
- OVS, 16, oversample ticks per bit; must be 8 or 16.
- SYNC_STAGES, 2, input synchroniser depth (≥2).
- TOC_W, 10, timeout counter width; must satisfy 2^TOC_W > 48*OVS.

Ports:
- clk  in  1  system clock.
- wb_rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- enable  in  1  oversample tick, one clk wide, OVS per bit time.
- lcr  in  8  line control: [1:0] data bits−5, [2] 2 stop bits, [3] PE, [4] EP, [5] stick parity.
- srx_pad_i  in  1  asynchronous serial input, idle high.
- rf_pop  in  1  FIFO pop strobe.
- fifo_empty  in  1  FIFO empty flag.
- rf_push  out  1  one-clk push strobe.
- rf_data_in  out  12  record {data[7:0], noise, break, parity_err, framing_err}.
- rstate  out  4  current FSM state.
- counter_t  out  TOC_W  timeout counter.
- rx_timeout  out  1  asserted when counter_t==0 and !fifo_empty.

## Operation
- Input path: srx_pad_i passes through the SYNC_STAGES synchroniser (reset 1), giving rx_s.
- All state and counter updates happen only on cycles with enable=1. rf_push is the exception.
- Frame length in bits: F = 1 + (5+lcr[1:0]) + lcr[3] + 1 + lcr[2].
- Sampling: within each bit, sample rx_s at ticks OVS/2−1, OVS/2 and OVS/2+1, counted from the bit start.
  - Bit value = majority of the three samples.
  - noise is set if the three samples disagree in any bit of the frame, start bit included.
- States:
  - IDLE: wait for rx_s=0.
  - START: majority at mid-bit. 1 → IDLE (glitch rejected, no push). 0 → DATA.
  - DATA: shift LSB first. Data bits above the configured length are 0.
  - PARITY: entered only if lcr[3]=1. Expected parity:
    - even when EP=1, odd when EP=0;
    - when stick parity is set, the expected bit is the constant ~EP.
    - parity_err = received parity ≠ expected parity.
  - STOP1: framing_err = !majority.
  - STOP2: entered only if lcr[2]=1. framing_err |= !majority.
  - PUSH: wait until rx_s=1 or break_det.
    - break_det → push {8'h00, 0, 1, 0, 0} and go to WAIT_IDLE.
    - Otherwise push the character record and go to IDLE.
  - WAIT_IDLE: wait for rx_s=1, then go to IDLE.
- Break detector (counter_b):
  - Loaded with F*OVS−1 on any enable tick with rx_s=1.
  - Decremented on enable ticks while rx_s=0, saturating at 0.
  - break_det = (counter_b==0).
  - At most one break record is pushed per low period.
- Timeout value: TOC = 4*F*OVS−1.
- counter_t:
  - Reloaded to TOC on any clk cycle where rf_push, rf_pop or fifo_empty is 1 (enable not required).
  - Otherwise decremented on enable ticks while nonzero.
- State encoding (shared constants): IDLE=0, START=1, DATA=2, PARITY=3, STOP1=4, STOP2=5, PUSH=6, WAIT_IDLE=7. Any other value → IDLE on the next enable.

## Timing
- Reset values: rstate=IDLE, rf_push=0, rf_data_in=0, counter_t=10*4*OVS−1 (639 for OVS=16), counter_b=10*OVS−1, synchroniser=all 1s, rx_timeout=0.
- Start edge to START entry: SYNC_STAGES clk plus up to 1 enable tick.
- rf_push: registered; high for exactly one clk cycle, following the enable tick on which PUSH resolves. It drops on the next clk regardless of enable. rf_data_in is valid in the same cycle and holds until the next push.
- lcr must be stable while rstate≠IDLE. Changes take effect at the next START entry. The TOC reload always uses the current lcr.
- Simultaneous events:
  - rf_pop with rf_push: a single reload.
  - break_det and rx_s rising on the same tick: the break record takes priority.
- Reset mid-frame: the frame is discarded, no push, and all registers return to reset values on the next clk.

## Structure
- Package uart_rx_pkg holds:
  - state constants;
  - record bit positions (DATA_MSB=11, NOISE=3, BREAK=2, PERR=1, FERR=0);
  - REC_W=12.
- Sub-module uart_rx_sampler: synchroniser, per-bit tick counter and 3-sample majority/noise logic. Outputs bit_value, bit_done and mid_tick.
- The FSM, break counter and timeout counter live in uart_rx_core.

## Test plan
- 8N1 (lcr=0x03), OVS=16, byte 0xA5 → one rf_push; rf_data_in=0xA50; push within 10*16+3 enable ticks of the start edge.
- 7E1 (lcr=0x1A), byte 0x41 sent with parity bit 1 → parity_err=1, data=0x41. Same frame with correct parity → parity_err=0.
- 8N2 (lcr=0x07), second stop bit low → framing_err=1. Line then held high → returns to IDLE and the next byte 0x3C is received clean.
- Start pulse low for 4 ticks only → rstate back to IDLE, no push. Single flipped mid-sample on data bit 3 of 0x55 → data=0x55, noise=1.
- Line low for 30 bit-times at 8N1 → exactly one push of 0x004 (break). Next push occurs only after the line returns high and a new start bit arrives.
- One record pushed, no pops, fifo_empty=0, 8N1 → rx_timeout after 640 enable ticks. rf_pop at tick 300 reloads counter_t to 639. wb_rst_i pulsed mid-frame → no push, counter_t=639.
